parity_frame_rx: RTL and testbench



---
 rtl/nand2tetris_pkg.sv | 18 +
 rtl/parity_frame_rx_if.sv | 31 +++
 rtl/parity_accum.sv | 29 ++
 rtl/parity_frame_rx.sv | 104 ++++++++++
 tb/tb_parity_frame_rx.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/nand2tetris_pkg.sv
// Shared definitions for the nand2tetris-side blocks: Hack word width,
// receiver state encoding and the error-counter width/saturating helper.
package nand2tetris_pkg;

    localparam int HACK_WIDTH = 16;
    localparam int ERRCNT_W   = 8;

    typedef enum logic [0:0] {
        RX_RECV = 1'b0,
        RX_HOLD = 1'b1
    } rx_state_t;

    // Saturating increment; the counter sticks at all-ones.
    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (&v) ? v : v + ERRCNT_W'(1);
    endfunction

endpackage

// File: rtl/parity_frame_rx_if.sv
// Serial-in / word-out bus of the even-parity frame receiver.
// master = bit source plus word consumer, slave = the receiver.
interface parity_frame_rx_if
    import nand2tetris_pkg::*;
#(
    parameter int WIDTH = HACK_WIDTH
);

    // Handshake rule for both sides: an item moves on a rising clock edge
    // where valid && ready; valid may not wait on ready, and a producer holds
    // its payload steady until the transfer edge.
    logic             s_valid;
    logic             s_bit;
    logic             s_ready;
    logic             s_clear;
    logic [WIDTH-1:0] m_data;
    logic             m_parity_ok;
    logic             m_valid;
    logic             m_ready;

    modport master (
        output s_valid, s_bit, s_clear, m_ready,
        input  s_ready, m_data, m_parity_ok, m_valid
    );

    modport slave (
        input  s_valid, s_bit, s_clear, m_ready,
        output s_ready, m_data, m_parity_ok, m_valid
    );

endinterface

// File: rtl/parity_accum.sv
// One-bit running parity register (XOR cell feedback) with a combinational
// check output (XNOR of the running parity and the incoming parity bit).
module parity_accum (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    input  logic bit_in,
    output logic acc,
    output logic check
);

    logic acc_next;

    assign acc_next = acc ^ bit_in;
    assign check    = ~(acc ^ bit_in);

    // Clear wins over enable so an abort or frame end always restarts at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= 1'b0;
        end else if (clear) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/parity_frame_rx.sv
// Even-parity frame receiver: WIDTH data bits LSB first, then a parity bit;
// presents word + pass flag. Define PARITY_FRAME_RX_ERRCNT_EN for err_count.
module parity_frame_rx
    import nand2tetris_pkg::*;
#(
    parameter int WIDTH = HACK_WIDTH
) (
    input  logic                clk,
    input  logic                reset_n,
    parity_frame_rx_if.slave    bus,
    output rx_state_t           dbg_state
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [0:0]       ST_RECV  = RX_RECV;
    localparam logic [0:0]       ST_HOLD  = RX_HOLD;

    logic [0:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] data_q;
    logic             ok_q;

    logic in_recv;
    logic take;
    logic take_data;
    logic take_par;
    logic xfer;
    logic acc_clear;
    logic acc;
    logic check;

    assign in_recv = (state_q == ST_RECV);

    // s_clear outranks acceptance: the bit offered alongside it is dropped.
    assign take      = in_recv && bus.s_valid && !bus.s_clear;
    assign take_data = take && (cnt_q != CNT_LAST);
    assign take_par  = take && (cnt_q == CNT_LAST);
    assign xfer      = !in_recv && bus.m_ready;
    assign acc_clear = (in_recv && bus.s_clear) || take_par;

    parity_accum u_accum (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (acc_clear),
        .en      (take_data),
        .bit_in  (bus.s_bit),
        .acc     (acc),
        .check   (check)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RECV;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            ok_q    <= 1'b0;
        end else if (state_q == ST_RECV) begin
            if (bus.s_clear) begin
                cnt_q   <= '0;
                shreg_q <= '0;
            end else if (take_data) begin
                // Right shift: after WIDTH bits the first one lands in bit 0.
                shreg_q <= {bus.s_bit, shreg_q[WIDTH-1:1]};
                cnt_q   <= cnt_q + CNT_W'(1);
            end else if (take_par) begin
                data_q  <= shreg_q;
                ok_q    <= check;
                cnt_q   <= '0;
                state_q <= ST_HOLD;
            end
        end else begin
            if (bus.m_ready) begin
                state_q <= ST_RECV;
            end
        end
    end

    assign bus.s_ready     = in_recv;
    assign bus.m_valid     = !in_recv;
    assign bus.m_data      = data_q;
    assign bus.m_parity_ok = ok_q;
    assign dbg_state       = rx_state_t'(state_q);

`ifdef PARITY_FRAME_RX_ERRCNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (xfer && !ok_q) begin
            err_count <= sat_inc(err_count);
        end
    end
`else
    logic unused_xfer;
    assign unused_xfer = xfer;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: even/odd frames, backpressure, gapped
// input, abort, async reset in HOLD. Honors PARITY_FRAME_RX_ERRCNT_EN.
module tb_parity_frame_rx;
  import nand2tetris_pkg::*;

  localparam int WIDTH = 16;

  logic clk;
  logic reset_n;
  rx_state_t dbg_state;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  parity_frame_rx_if #(.WIDTH(WIDTH)) bus ();

  parity_frame_rx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives WIDTH data bits LSB first then the parity bit, one per cycle;
  // returns at the negedge following the parity-accepting edge.
  task automatic send_frame(input logic [WIDTH-1:0] d, input logic p);
    for (int i = 0; i <= WIDTH; i++) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_clear = 1'b0;
      bus.s_bit   = (i < WIDTH) ? d[i] : p;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  initial begin
    logic [WIDTH:0] frame;
    int cyc;

    reset_n     = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_bit   = 1'b0;
    bus.s_clear = 1'b0;
    bus.m_ready = 1'b0;

    #1;
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'h0);
    chk("rst_ok", 32'(bus.m_parity_ok), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(RX_RECV));
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    chk("rst_errcnt", 32'(err_count), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // even frame, m_ready already high while m_valid is low
    bus.m_ready = 1'b1;
    send_frame(16'h00FF, 1'b0);
    chk("even_valid", 32'(bus.m_valid), 32'd1);
    chk("even_data", 32'(bus.m_data), 32'h00FF);
    chk("even_ok", 32'(bus.m_parity_ok), 32'd1);
    chk("even_state", 32'(dbg_state), 32'(RX_HOLD));
    @(negedge clk);
    chk("even_xfer_valid", 32'(bus.m_valid), 32'd0);
    chk("even_xfer_ready", 32'(bus.s_ready), 32'd1);

    // bad parity
    send_frame(16'h0001, 1'b0);
    chk("bad_data", 32'(bus.m_data), 32'h0001);
    chk("bad_ok", 32'(bus.m_parity_ok), 32'd0);
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    chk("bad_errcnt_pre", 32'(err_count), 32'd0);
`endif
    @(negedge clk);
    chk("bad_xfer_valid", 32'(bus.m_valid), 32'd0);
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    chk("bad_errcnt_post", 32'(err_count), 32'd1);
`endif

    // backpressure: bits and s_clear offered in HOLD must be ignored
    bus.m_ready = 1'b0;
    send_frame(16'h0F0F, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.s_valid = 1'b1;
      bus.s_bit   = 1'b1;
      bus.s_clear = i[0];
      @(negedge clk);
    end
    chk("bp_valid", 32'(bus.m_valid), 32'd1);
    chk("bp_s_ready", 32'(bus.s_ready), 32'd0);
    chk("bp_data", 32'(bus.m_data), 32'h0F0F);
    chk("bp_ok", 32'(bus.m_parity_ok), 32'd1);
    bus.s_valid = 1'b0;
    bus.s_clear = 1'b0;
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("bp_xfer_valid", 32'(bus.m_valid), 32'd0);
    chk("bp_xfer_ready", 32'(bus.s_ready), 32'd1);
    send_frame(16'hA5A5, 1'b0);
    chk("bp_next_data", 32'(bus.m_data), 32'hA5A5);
    chk("bp_next_ok", 32'(bus.m_parity_ok), 32'd1);
    @(negedge clk);

    // gapped input: valid on odd cycles only, cycle 1 carries the first bit
    frame = {1'b1, 16'h8000};
    cyc = 1;
    bus.s_valid = 1'b1;
    bus.s_bit   = frame[0];
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.m_valid) break;
      bus.s_valid = cyc[0];
      bus.s_bit   = ((cyc - 1) / 2 <= WIDTH) ? frame[(cyc - 1) / 2] : 1'b0;
    end
    bus.s_valid = 1'b0;
    chk("gap_latency", 32'(cyc), 32'd34);
    chk("gap_data", 32'(bus.m_data), 32'h8000);
    chk("gap_ok", 32'(bus.m_parity_ok), 32'd1);
    @(negedge clk);

    // abort: five ones, then s_clear with a bit offered, then a full frame
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = 1'b1;
      bus.s_bit   = 1'b1;
      @(negedge clk);
    end
    bus.s_clear = 1'b1;
    send_frame(16'h1234, 1'b1);
    chk("abort_valid", 32'(bus.m_valid), 32'd1);
    chk("abort_data", 32'(bus.m_data), 32'h1234);
    chk("abort_ok", 32'(bus.m_parity_ok), 32'd1);
    repeat (4) @(negedge clk);
    chk("abort_single", 32'(bus.m_valid), 32'd0);

    // async reset while holding a result
    bus.m_ready = 1'b0;
    send_frame(16'hFFFF, 1'b1);
    chk("hold_valid", 32'(bus.m_valid), 32'd1);
    chk("hold_ok", 32'(bus.m_parity_ok), 32'd0);
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    chk("hold_errcnt", 32'(err_count), 32'd1);
`endif
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.m_valid), 32'd0);
    chk("arst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("arst_data", 32'(bus.m_data), 32'h0);
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    chk("arst_errcnt", 32'(err_count), 32'd0);
`endif
    #1 reset_n = 1'b1;
    bus.m_ready = 1'b1;
    send_frame(16'hFFFF, 1'b0);
    chk("post_rst_data", 32'(bus.m_data), 32'hFFFF);
    chk("post_rst_ok", 32'(bus.m_parity_ok), 32'd1);
    @(negedge clk);
    chk("post_rst_xfer", 32'(bus.m_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
